// File: rtl/sram_arb_pkg.sv
// Shared types and default constants for the SRAM arbiter.
package sram_arb_pkg;

  localparam int DEF_NUM_PORTS   = 3;
  localparam int DEF_ADDR_W      = 17;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_TIMEOUT_CYC = 255;

  // Grant index covers up to four ports; the BUSY timer covers TIMEOUT_CYC up to 255.
  localparam int IDX_W = 2;
  localparam int TMR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection for sram_arbiter.
// SRAM_ARB_ROUND_ROBIN_EN: search starts at `start` and wraps; otherwise lowest index wins.
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic [IDX_W-1:0]     grant,
  output logic                 valid
);

  logic [NUM_PORTS-1:0] vec_s;
  logic [IDX_W-1:0]     pos_s;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic [IDX_W:0] sum_s;

  // Rotate so that bit 0 is the port at `start`, then map the hit back.
  assign vec_s = NUM_PORTS'({req, req} >> start);
  assign sum_s = {1'b0, start} + {1'b0, pos_s};
  assign grant = (sum_s >= (IDX_W + 1)'(NUM_PORTS)) ?
                 IDX_W'(sum_s - (IDX_W + 1)'(NUM_PORTS)) : IDX_W'(sum_s);
`else
  logic unused_start_s;

  assign vec_s          = req;
  assign unused_start_s = ^start;
  assign grant          = pos_s;
`endif

  // Lowest set bit of the (possibly rotated) request vector.
  always_comb begin
    pos_s = {IDX_W{1'b0}};
    valid = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      pos_s = vec_s[i] ? IDX_W'(i) : pos_s;
      valid = valid | vec_s[i];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Multi-port arbiter in front of a single SRAM controller, one access outstanding at a time.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        err,
  output logic                        ctl_read_req,
  output logic                        ctl_write_req,
  output logic [ADDR_W-1:0]           ctl_addr,
  output logic [DATA_W-1:0]           ctl_wdata,
  input  logic [DATA_W-1:0]           ctl_rdata,
  input  logic                        ctl_ready
);

  arb_state_e           state_r, state_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic                 pick_valid_s;
  logic                 sel_we_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [DATA_W-1:0]    sel_wdata_s;
  logic [NUM_PORTS-1:0] grant_hot_s;
  logic                 timeout_s;

  logic [IDX_W-1:0]     grant_r;
  logic [IDX_W-1:0]     rr_ptr_r;
  logic                 we_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [DATA_W-1:0]    wdata_r;
  logic [DATA_W-1:0]    rdata_r;
  logic [NUM_PORTS-1:0] ack_r;
  logic                 err_r;
  logic                 rd_req_r;
  logic                 wr_req_r;
  logic [TMR_W-1:0]     timer_r;

  // rr_ptr_r is the first port searched; it moves just past each winner.
  sram_arb_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req   (req),
    .start (rr_ptr_r),
    .grant (pick_idx_s),
    .valid (pick_valid_s)
  );

  assign timeout_s = (timer_r == TMR_W'(TIMEOUT_CYC - 1));

  // Fetch the winning port's request fields and decode the held grant.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    grant_hot_s = {NUM_PORTS{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_we_s       = (pick_idx_s == IDX_W'(i)) ? we[i] : sel_we_s;
      sel_addr_s     = (pick_idx_s == IDX_W'(i)) ? addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
      sel_wdata_s    = (pick_idx_s == IDX_W'(i)) ? wdata[i*DATA_W +: DATA_W] : sel_wdata_s;
      grant_hot_s[i] = (grant_r == IDX_W'(i));
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = pick_valid_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_s = ST_BUSY;
      ST_BUSY:  state_s = (ctl_ready || timeout_s) ? ST_DONE : ST_BUSY;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Access capture, controller handshake, timeout timer and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r  <= {IDX_W{1'b0}};
      rr_ptr_r <= {IDX_W{1'b0}};
      we_r     <= 1'b0;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= {DATA_W{1'b0}};
      rdata_r  <= {DATA_W{1'b0}};
      ack_r    <= {NUM_PORTS{1'b0}};
      err_r    <= 1'b0;
      rd_req_r <= 1'b0;
      wr_req_r <= 1'b0;
      timer_r  <= {TMR_W{1'b0}};
    end else begin
      rd_req_r <= 1'b0;
      wr_req_r <= 1'b0;
      ack_r    <= {NUM_PORTS{1'b0}};
      err_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            grant_r  <= pick_idx_s;
            we_r     <= sel_we_s;
            addr_r   <= sel_addr_s;
            wdata_r  <= sel_wdata_s;
            rd_req_r <= ~sel_we_s;
            wr_req_r <= sel_we_s;
            rr_ptr_r <= (pick_idx_s == IDX_W'(NUM_PORTS - 1)) ?
                        {IDX_W{1'b0}} : pick_idx_s + IDX_W'(1);
          end
        end
        ST_ISSUE: timer_r <= {TMR_W{1'b0}};
        ST_BUSY: begin
          // A response in the final timeout cycle still counts as a normal completion.
          if (ctl_ready) begin
            ack_r <= grant_hot_s;
            if (!we_r) begin
              rdata_r <= ctl_rdata;
            end
          end else if (timeout_s) begin
            ack_r <= grant_hot_s;
            err_r <= 1'b1;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ack           = ack_r;
  assign err           = err_r;
  assign rdata         = rdata_r;
  assign ctl_read_req  = rd_req_r;
  assign ctl_write_req = wr_req_r;
  assign ctl_addr      = addr_r;
  assign ctl_wdata     = wdata_r;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of requester ports (2..4).
REQ-002 SHALL have parameter ADDR_W, default 17, SRAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, maximum BUSY cycles before abort (1..255).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  in  NUM_PORTS  per-port access request, held until ack.
REQ-008 SHALL have port we  in  NUM_PORTS  per-port 1 = write, 0 = read.
REQ-009 SHALL have port addr  in  NUM_PORTS x ADDR_W  per-port address.
REQ-010 SHALL have port wdata  in  NUM_PORTS x DATA_W  per-port write data.
REQ-011 SHALL have port ack  out  NUM_PORTS  one-cycle completion pulse to the granted port.
REQ-012 SHALL have port rdata  out  DATA_W  shared read data, valid in the ack cycle.
REQ-013 SHALL have port err  out  1  one-cycle timeout pulse, coincident with ack.
REQ-014 SHALL have ports ctl_read_req, ctl_write_req  out  1 each  requests to the SRAM controller.
REQ-015 SHALL have ports ctl_addr  out  ADDR_W and ctl_wdata  out  DATA_W  to the controller.
REQ-016 SHALL have ports ctl_rdata  in  DATA_W and ctl_ready  in  1  controller completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, BUSY, DONE.
REQ-018 In IDLE with any req bit high, SHALL register grant index, we, addr, wdata of the winner, then go to ISSUE.
REQ-019 ISSUE SHALL assert exactly one of ctl_read_req/ctl_write_req for exactly one cycle, then go to BUSY.
REQ-020 ctl_addr and ctl_wdata SHALL be driven from registered values, stable from ISSUE through DONE inclusive.
REQ-021 In BUSY, ctl_ready high SHALL capture ctl_rdata into rdata and go to DONE.
REQ-022 DONE SHALL pulse ack[grant] for one cycle, then return to IDLE; minimum req-to-ack latency 4 cycles plus controller latency.
REQ-023 BUSY counter reaching TIMEOUT_CYC without ctl_ready SHALL go to DONE with err=1 and rdata unchanged.
REQ-024 ctl_ready outside BUSY SHALL be ignored.
REQ-025 Requester dropping req after grant SHALL NOT abort the access; ack still pulses.
REQ-026 Requests arriving in non-IDLE states SHALL wait; no more than one access outstanding.
REQ-027 rdata SHALL hold its last value between acks; writes SHALL NOT modify rdata.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, ack=0, err=0, ctl_read_req=0, ctl_write_req=0, ctl_addr=0, ctl_wdata=0, rdata=0, grant=0, round-robin pointer=0.
REQ-029 Reset mid-access SHALL discard the access with no ack; first post-reset grant SHALL follow REQ-018.

Configuration
REQ-030 With SRAM_ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first requesting port after the last granted index (wrapping NUM_PORTS-1 to 0).
REQ-031 Without SRAM_ARB_ROUND_ROBIN_EN, the winner SHALL be the lowest-index requesting port (fixed priority).

Structure
REQ-032 Package sram_arb_pkg SHALL hold the state enum and the default width/timeout constants.
REQ-033 Winner selection SHALL be a sub-module sram_arb_pick (req, last grant -> grant index, valid), combinational.

Verification
REQ-034 Port0 read addr 0x00010, controller returns 0xBEEF after 3 cycles -> one ack[0], rdata=0xBEEF, err=0.
REQ-035 Ports 0,1,2 request together, repeated -> RR build grants 0,1,2,0; fixed build grants 0,0,0 while port0 holds req.
REQ-036 Port1 write 0x1FFFF/0xA5A5, port1 changes addr after grant -> ctl_addr stays 0x1FFFF, ctl_wdata 0xA5A5 until ack[1].
REQ-037 ctl_ready never returned, TIMEOUT_CYC=8 -> ack and err pulse together after 8 BUSY cycles, then FSM returns to IDLE.
REQ-038 rst_n low during BUSY -> no ack, ctl_* zero asynchronously; next request completes normally.
